cdc_hs_tx: RTL and testbench



---
 rtl/cdc_hs_pkg.sv | 17 +
 rtl/cdc_data.sv | 26 ++
 rtl/cdc_hs_tx.sv | 98 +++++++++
 tb/tb_cdc_hs_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_hs_pkg.sv
// Shared types and sizing helpers for the two-phase handshake source end.
package cdc_hs_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT_ACK
  } hs_tx_state_t;

  localparam int SYNC_STAGES = 2;

  // Bits needed to hold values 0..maxval, never less than one.
  function automatic int cnt_width(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/cdc_data.sv
// Two-stage synchronizer for slow, level-encoded signals entering the clk domain.
module cdc_data #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/cdc_hs_tx.sv
// Source end of a toggle req/ack crossing: holds a word on tx_data, toggles
// tx_req after a setup delay and waits for the destination's mirrored ack.
module cdc_hs_tx
  import cdc_hs_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int SETUP_CYCLES = 1,
  parameter int TIMEOUT      = 0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_req,
  input  logic             ack_async,
  output logic             busy,
  output logic             timeout
);

  localparam int SW = cnt_width(SETUP_CYCLES - 1);
  localparam int TW = cnt_width(TIMEOUT);

  hs_tx_state_t     state_reg, state_next;
  logic [WIDTH-1:0] data_reg;
  logic             req_reg;
  logic             ready_reg;
  logic             timeout_reg;
  logic [SW-1:0]    setup_cnt_reg;
  logic [TW-1:0]    wait_cnt_reg;
  logic             ack_s;

  cdc_data #(.WIDTH(1)) ack_SYNC_ATTR (
    .clk  (clk),
    .nrst (nrst),
    .d    (ack_async),
    .q    (ack_s)
  );

  // Capture is gated by the registered ready so nothing is taken on the release edge.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (in_valid && ready_reg) state_next = SETUP;
      SETUP:    if (setup_cnt_reg == '0) state_next = WAIT_ACK;
      WAIT_ACK: if (ack_s == req_reg) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg     <= IDLE;
      data_reg      <= '0;
      req_reg       <= 1'b0;
      ready_reg     <= 1'b0;
      timeout_reg   <= 1'b0;
      setup_cnt_reg <= '0;
      wait_cnt_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      ready_reg   <= (state_next == IDLE);
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid && ready_reg) begin
            data_reg      <= in_data;
            setup_cnt_reg <= SW'(SETUP_CYCLES - 1);
          end
        end
        SETUP: begin
          if (setup_cnt_reg == '0) begin
            req_reg      <= ~req_reg;
            wait_cnt_reg <= '0;
          end else begin
            setup_cnt_reg <= setup_cnt_reg - 1'b1;
          end
        end
        WAIT_ACK: begin
          // Saturate at TIMEOUT; the pulse fires only on the step into it.
          if (TIMEOUT != 0 && wait_cnt_reg != TW'(TIMEOUT)) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
            timeout_reg  <= (wait_cnt_reg == TW'(TIMEOUT - 1));
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready = ready_reg;
  assign tx_data  = data_reg;
  assign tx_req   = req_reg;
  assign busy     = (state_reg != IDLE);
  assign timeout  = timeout_reg;

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Bench for cdc_hs_tx: two instances (setup 1 / timeout 8, setup 3 / no timeout)
// checked cycle by cycle against a timing model built from capture times.
module tb_cdc_hs_tx;

  localparam int S0 = 1;
  localparam int S1 = 3;

  logic        clk = 1'b0;
  logic        nrst;
  logic [31:0] in_data;
  logic [1:0]  vld, rdy, req, bsy, tmo, loop, man;
  logic [31:0] txd [2];
  logic        ack0, ack1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic        m_old  [2];
  logic        m_new  [2];
  logic [31:0] m_data [2];
  int          m_cap  [2];

  always #5 clk = ~clk;

  assign ack0 = loop[0] ? req[0] : man[0];
  assign ack1 = loop[1] ? req[1] : man[1];

  cdc_hs_tx #(.WIDTH(32), .SETUP_CYCLES(S0), .TIMEOUT(8)) dut0 (
    .clk(clk), .nrst(nrst), .in_data(in_data), .in_valid(vld[0]), .in_ready(rdy[0]),
    .tx_data(txd[0]), .tx_req(req[0]), .ack_async(ack0), .busy(bsy[0]), .timeout(tmo[0])
  );

  cdc_hs_tx #(.WIDTH(32), .SETUP_CYCLES(S1), .TIMEOUT(0)) dut1 (
    .clk(clk), .nrst(nrst), .in_data(in_data), .in_valid(vld[1]), .in_ready(rdy[1]),
    .tx_data(txd[1]), .tx_req(req[1]), .ack_async(ack1), .busy(bsy[1]), .timeout(tmo[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int setup_of(input int i);
    return (i == 0) ? S0 : S1;
  endfunction

  // Loopback timing: req toggles S edges after capture, idle again 3 edges later.
  function automatic logic exp_rdy(input int i);
    return (cyc >= m_cap[i] + setup_of(i) + 3);
  endfunction

  function automatic logic exp_req(input int i);
    return (cyc >= m_cap[i] + setup_of(i)) ? m_new[i] : m_old[i];
  endfunction

  function automatic void model_reset(input int i, input logic lvl, input logic [31:0] d);
    m_old[i]  = lvl;
    m_new[i]  = lvl;
    m_data[i] = d;
    m_cap[i]  = cyc - 100;
  endfunction

  task automatic step(input int i, input logic v, input logic [31:0] d, output logic took);
    took    = v && exp_rdy(i);
    vld[i]  = v;
    in_data = d;
    tick();
    if (took) begin
      m_old[i]  = m_new[i];
      m_new[i]  = ~m_new[i];
      m_data[i] = d;
      m_cap[i]  = cyc;
      $display("dut%0d capture data=%h at cycle %0d", i, d, cyc);
    end
    chk($sformatf("dut%0d.in_ready", i), {31'd0, rdy[i]}, {31'd0, exp_rdy(i)});
    chk($sformatf("dut%0d.busy", i), {31'd0, bsy[i]}, {31'd0, !exp_rdy(i)});
    chk($sformatf("dut%0d.tx_req", i), {31'd0, req[i]}, {31'd0, exp_req(i)});
    chk($sformatf("dut%0d.tx_data", i), txd[i], m_data[i]);
    chk($sformatf("dut%0d.timeout", i), {31'd0, tmo[i]}, 32'd0);
  endtask

  task automatic loop_run(input int i, input int n);
    int   got;
    logic t;
    got = 0;
    loop[i] = 1'b1;
    for (int k = 0; k < n * 12 + 40 && got < n; k++) begin
      step(i, ($urandom_range(0, 3) != 0), $urandom, t);
      if (t) got++;
    end
    chk($sformatf("dut%0d.captures", i), got, n);
    for (int k = 0; k < 10 && !exp_rdy(i); k++) step(i, 1'b0, $urandom, t);
    vld[i] = 1'b0;
  endtask

  initial begin
    logic        t;
    logic        r;
    logic [31:0] d;
    int          got, cap, cap_a, cap_b;

    // Reset with valid held high: everything stays 0, no capture on release.
    nrst = 1'b0; vld = 2'b11; loop = 2'b11; man = 2'b00; in_data = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("rst%0d.in_ready", i), {31'd0, rdy[i]}, 32'd0);
        chk($sformatf("rst%0d.tx_req", i), {31'd0, req[i]}, 32'd0);
        chk($sformatf("rst%0d.tx_data", i), txd[i], 32'd0);
        chk($sformatf("rst%0d.busy", i), {31'd0, bsy[i]}, 32'd0);
        chk($sformatf("rst%0d.timeout", i), {31'd0, tmo[i]}, 32'd0);
      end
    end
    nrst = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rel%0d.in_ready", i), {31'd0, rdy[i]}, 32'd1);
      chk($sformatf("rel%0d.tx_data", i), txd[i], 32'd0);
      chk($sformatf("rel%0d.busy", i), {31'd0, bsy[i]}, 32'd0);
      model_reset(i, 1'b0, 32'd0);
    end
    vld = 2'b00;

    // Back-to-back loopback words on the setup=1 instance.
    got = 0; cap_a = 0; cap_b = 0;
    for (int k = 0; k < 12; k++) begin
      d = (got == 0) ? 32'hA5A5_0001 : 32'h0000_0002;
      step(0, (got < 2), d, t);
      if (t) begin
        if (got == 0) cap_a = cyc; else cap_b = cyc;
        got++;
      end
    end
    vld[0] = 1'b0;
    chk("b2b.captures", got, 2);
    chk("b2b.spacing", cap_b - cap_a, 5);
    chk("b2b.req_final", {31'd0, req[0]}, 32'd0);

    // Random loopback traffic on both instances.
    loop_run(0, 6);
    loop_run(1, 5);

    // Timeout: request 0->1 with the ack held low.
    if (m_new[0]) loop_run(0, 1);
    loop[0] = 1'b0; man[0] = 1'b0;
    d = $urandom; vld[0] = 1'b1; in_data = d;
    tick();
    vld[0] = 1'b0; cap = cyc;
    chk("to.capture", txd[0], d);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("to.pulse", {31'd0, tmo[0]}, {31'd0, (cyc == cap + 9)});
      chk("to.busy", {31'd0, bsy[0]}, 32'd1);
      chk("to.tx_req", {31'd0, req[0]}, 32'd1);
      chk("to.tx_data", txd[0], d);
    end
    man[0] = 1'b1;
    tick(); chk("to.ack_e1", {31'd0, bsy[0]}, 32'd1);
    tick(); chk("to.ack_e2", {31'd0, bsy[0]}, 32'd1);
    tick(); chk("to.ack_e3", {31'd0, bsy[0]}, 32'd0);
    chk("to.ready", {31'd0, rdy[0]}, 32'd1);
    $display("dut0 timeout transfer done at cycle %0d", cyc);
    model_reset(0, 1'b1, d);
    loop[0] = 1'b1;

    // Spurious ack toggles in IDLE and SETUP on the setup=3 instance.
    r = m_new[1];
    loop[1] = 1'b0; man[1] = r;
    for (int k = 0; k < 3; k++) tick();
    man[1] = ~r;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("sp.idle_busy", {31'd0, bsy[1]}, 32'd0);
      chk("sp.idle_ready", {31'd0, rdy[1]}, 32'd1);
      chk("sp.idle_req", {31'd0, req[1]}, {31'd0, r});
    end
    d = $urandom; vld[1] = 1'b1; in_data = d;
    tick();
    vld[1] = 1'b0; cap = cyc;
    man[1] = r;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("sp.busy", {31'd0, bsy[1]}, 32'd1);
      chk("sp.tx_req", {31'd0, req[1]}, {31'd0, (cyc >= cap + S1) ? ~r : r});
      chk("sp.tx_data", txd[1], d);
      chk("sp.timeout", {31'd0, tmo[1]}, 32'd0);
    end
    man[1] = ~r;
    tick(); tick();
    chk("sp.ack_e2", {31'd0, bsy[1]}, 32'd1);
    tick();
    chk("sp.ack_e3", {31'd0, bsy[1]}, 32'd0);
    $display("dut1 spurious-ack transfer done at cycle %0d", cyc);
    model_reset(1, ~r, d);
    loop_run(1, 2);

    // Reset while waiting for ack with tx_req high.
    if (m_new[0]) loop_run(0, 1);
    loop[0] = 1'b0; man[0] = 1'b0;
    d = $urandom; vld[0] = 1'b1; in_data = d;
    tick();
    vld[0] = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("mr.pre_req", {31'd0, req[0]}, 32'd1);
    chk("mr.pre_busy", {31'd0, bsy[0]}, 32'd1);
    loop[1] = 1'b0; man[1] = 1'b0;
    nrst = 1'b0;
    tick();
    chk("mr.tx_req", {31'd0, req[0]}, 32'd0);
    chk("mr.tx_data", txd[0], 32'd0);
    chk("mr.busy", {31'd0, bsy[0]}, 32'd0);
    chk("mr.dut1_req", {31'd0, req[1]}, 32'd0);
    nrst = 1'b1;
    tick();
    chk("mr.ready0", {31'd0, rdy[0]}, 32'd1);
    chk("mr.ready1", {31'd0, rdy[1]}, 32'd1);
    model_reset(0, 1'b0, 32'd0);
    model_reset(1, 1'b0, 32'd0);
    loop = 2'b11;
    loop_run(0, 3);
    loop_run(1, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
